arb_request_manager: RTL
========================

// Module: arb_request_manager
// PURPOSE
//  Requester-side front end for round_robin_arbitor: the other end of its request/grant interface.
//  Collects job submissions from N clients, queues them as per-client pending counts, and drives
//  the arbiter's request vector. Consumes grant/grant_id/stall, runs one fixed-length service
//  window per accepted grant, and reports each completion back to the owning client.
// PARAMETERS
//  N             8   number of clients; also the width of request and grant
//  DEPTH         4   max pending jobs per client (>=1)
//  SERVICE_CYCLES 3  cycles in BUSY per accepted grant (>=1)
// PORTS
//  clk          in   1          single clock, rising edge
//  reset_b      in   1          asynchronous, active-low reset
//  submit       in   N          one-cycle pulse per bit = one new job for client i
//  submit_full  out  N          client i pending count == DEPTH
//  request      out  N          to arbiter; registered
//  grant        in   N          from arbiter; one-hot or zero
//  grant_id     in   $clog2(N)  from arbiter; encoded index of grant
//  stall        in   1          from arbiter; high = grant not valid this cycle
//  done_valid   out  1          one-cycle pulse at end of a service window
//  done_id      out  $clog2(N)  owner of completed job; valid with done_valid
//  overflow_err out  1          sticky: a submit arrived while the client was full
//  proto_err    out  1          sticky: an illegal grant was seen
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - cnt[*]=0, state=IDLE, request=0, done_valid=0, done_id=0, both err=0.
//  Counters: cnt[i] is $clog2(DEPTH+1) bits wide.
//   - submit[i] & !full -> +1.
//   - Accepted grant to i -> -1.
//   - Both in the same cycle -> unchanged. This holds even when full, and the submit is not dropped.
//   - submit[i] while full with no grant to i -> job dropped, overflow_err<=1.
//  request (registered) = IDLE_next ? {cnt_next[i]!=0} : 0.
//   - One-cycle latency from submit to request.
//   - request is forced to 0 in every cycle the FSM is or will be BUSY.
//  FSM states: IDLE, BUSY.
//   - IDLE: a grant is accepted when stall==0 && grant!=0.
//     Legality checks: grant is one-hot, grant==(1<<grant_id), and cnt[grant_id]!=0.
//     Legal -> owner<=grant_id, cnt[owner]-1, timer<=SERVICE_CYCLES-1, go to BUSY.
//     Illegal -> proto_err<=1, grant ignored, stay in IDLE.
//   - IDLE with stall==1: grant is ignored and no error is raised.
//   - BUSY: all grant inputs are ignored. timer decrements each cycle.
//     When timer==0: done_valid=1, done_id=owner, go to IDLE. Requests resume next cycle.
//   - Grant to done_valid latency is SERVICE_CYCLES cycles.
//  Errors are cleared only by reset. submit_full is combinational from cnt.
//  Reset mid-BUSY: window aborted, no done_valid, all queued jobs discarded.
// STRUCTURE
//  - arb_pkg holds: state_t enum {IDLE,BUSY}; default N/DEPTH/SERVICE_CYCLES localparams;
//    function onehot_ok(grant, id).
//  - One sub-module, arb_req_counter: a single saturating up/down pending counter with a full flag.
//    It is instantiated N times by generate.
//  - The FSM, timer, request register and error flags live in the top.
// TESTING
//  1. Reset held 400ns with submit=8'hFF.
//     -> request=0, cnt=0, done_valid=0, no errors.
//  2. submit=8'h05 for 1 cycle.
//     -> request=8'h05 next cycle.
//     Then grant=8'h01, id=0, stall=0 -> request=0 for 3 cycles, done_valid with done_id=0,
//     then request=8'h04.
//  3. Five submit pulses to client 3 (DEPTH=4).
//     -> submit_full[3]=1 after the 4th pulse, overflow_err=1 after the 5th, cnt[3]=4.
//  4. At full, submit[3] and a legal grant to 3 in the same cycle.
//     -> cnt[3] stays 4, no overflow_err.
//  5. grant=8'h03, or grant=8'h04 with id=1, or a grant to a client with cnt==0.
//     -> proto_err=1, FSM stays IDLE, no counter change.
//  6. Grant under stall=1 -> ignored.
//     Reset asserted mid-BUSY -> no done_valid, all outputs at reset values.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, default sizing and the grant legality helper for the arbiter
// request manager.
package arb_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int N_DEF              = 8;
    localparam int DEPTH_DEF          = 4;
    localparam int SERVICE_CYCLES_DEF = 3;

    // Callers zero-extend grant/id into these fixed widths, so the helper
    // covers up to 32 clients.
    function automatic logic onehot_ok(input logic [31:0] grant, input logic [4:0] id);
        return grant == (32'd1 << id);
    endfunction

endpackage

// File: rtl/arb_request_manager_if.sv
// Client/arbiter-facing signal bundle of the request manager.
// The master side is the manager; the slave side is clients plus arbiter.
interface arb_request_manager_if #(parameter int N = 8) ();
    localparam int IW = $clog2(N);

    logic [N-1:0]  submit;
    logic [N-1:0]  submit_full;
    logic [N-1:0]  request;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          stall;
    logic          done_valid;
    logic [IW-1:0] done_id;
    logic          overflow_err;
    logic          proto_err;

    modport master (
        input  submit, grant, grant_id, stall,
        output submit_full, request, done_valid, done_id, overflow_err, proto_err
    );

    modport slave (
        output submit, grant, grant_id, stall,
        input  submit_full, request, done_valid, done_id, overflow_err, proto_err
    );
endinterface

// File: rtl/arb_req_counter.sv
// One client's pending-job counter: saturating up/down with full flag.
// A simultaneous submit and grant cancel, so a submit while full is kept.
module arb_req_counter #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic reset_b,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nz,
    output logic nz_next,
    output logic overflow
);
    logic [CW-1:0] cnt, cnt_next;

    assign full    = (cnt == CW'(DEPTH));
    assign nz      = (cnt != '0);
    assign nz_next = (cnt_next != '0);

    always_comb begin
        cnt_next = cnt;
        overflow = 1'b0;
        if (inc && !dec) begin
            if (full) overflow = 1'b1;
            else      cnt_next = cnt + 1'b1;
        end else if (dec && !inc && nz) begin
            cnt_next = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) cnt <= '0;
        else          cnt <= cnt_next;
    end
endmodule

// File: rtl/arb_request_manager.sv
// Requester-side front end of the round-robin arbiter: queues client jobs,
// drives the request vector and runs a fixed service window per grant.
module arb_request_manager
    import arb_pkg::*;
#(
    parameter int N              = N_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int SERVICE_CYCLES = SERVICE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_b,
    arb_request_manager_if.master bus
);
    localparam int IW = $clog2(N);
    localparam int TW = $clog2(SERVICE_CYCLES + 1);

    logic [N-1:0]  full, nz, nz_next, ovf, dec;
    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic [IW-1:0] owner;
    logic [N-1:0]  request_q;
    logic          overflow_err_q, proto_err_q;
    logic          grant_seen, legal, accept, window_end;

    for (genvar i = 0; i < N; i++) begin : g_cnt
        arb_req_counter #(.DEPTH(DEPTH)) u_cnt (
            .clk      (clk),
            .reset_b  (reset_b),
            .inc      (bus.submit[i]),
            .dec      (dec[i]),
            .full     (full[i]),
            .nz       (nz[i]),
            .nz_next  (nz_next[i]),
            .overflow (ovf[i])
        );
    end

    // Stalled grants and anything seen while BUSY are not even inspected.
    assign grant_seen = (state == IDLE) && !bus.stall && (bus.grant != '0);
    // Once grant == 1<<id holds, grant & nz is nonzero exactly when cnt[id] != 0.
    assign legal      = onehot_ok(32'(bus.grant), 5'(bus.grant_id)) && ((bus.grant & nz) != '0);
    assign accept     = grant_seen && legal;
    assign dec        = accept ? bus.grant : '0;
    assign window_end = (state == BUSY) && (timer == '0);

    always_comb begin
        state_next = state;
        if (accept)     state_next = BUSY;
        if (window_end) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state          <= IDLE;
            timer          <= '0;
            owner          <= '0;
            request_q      <= '0;
            overflow_err_q <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner <= bus.grant_id;
                timer <= TW'(SERVICE_CYCLES - 1);
            end else if (state == BUSY && timer != '0) begin
                timer <= timer - 1'b1;
            end
            request_q      <= (state_next == IDLE) ? nz_next : '0;
            overflow_err_q <= overflow_err_q | (|ovf);
            proto_err_q    <= proto_err_q | (grant_seen && !legal);
        end
    end

    assign bus.submit_full  = full;
    assign bus.request      = request_q;
    assign bus.done_valid   = window_end;
    assign bus.done_id      = owner;
    assign bus.overflow_err = overflow_err_q;
    assign bus.proto_err    = proto_err_q;
endmodule
